// File: rtl/bnn_pkg.sv
// ============================================================================
//  Module      : bnn_pkg
//  Description : Shared types and constants for the ifmap window address
//                generator.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ifgen_state_t;

    localparam logic PAD_NONE = 1'b0;
    localparam logic PAD_SAME = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ifmap_tap_counter.sv
// ============================================================================
//  Module      : ifmap_tap_counter
//  Description : Nested kx/ky/ox0/oy0 counters; exposes next-tap coordinates
//                and framing flags so the top can register them.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ifmap_tap_counter #(
    parameter int CW = 7,
    parameter int KW = 4,
    parameter int IW = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_adv,
    input  logic [KW-1:0]        i_k,
    input  logic [KW-1:0]        i_p,
    input  logic [1:0]           i_s,
    input  logic [IW-1:0]        i_size,
    output logic signed [CW-1:0] o_y_nxt,
    output logic signed [CW-1:0] o_x_nxt,
    output logic                 o_pad_nxt,
    output logic                 o_first_nxt,
    output logic                 o_last_nxt,
    output logic                 o_wlast_nxt
);

    localparam logic signed [CW-1:0] c_one = 1;

    logic [KW-1:0]        r_kx, r_ky;
    logic signed [CW-1:0] r_ox0, r_oy0;

    logic [KW-1:0]        w_kx_n, w_ky_n, w_kend;
    logic signed [CW-1:0] w_ox_n, w_oy_n;
    logic signed [CW-1:0] w_k, w_p, w_s, w_n, w_km1, w_lim, w_ox_step;
    logic                 w_kx_end, w_ky_end, w_tap_last, w_row_wrap;

    always_comb begin
        w_k        = signed'(CW'(i_k));
        w_p        = signed'(CW'(i_p));
        w_s        = signed'(CW'(i_s));
        w_n        = signed'(CW'(i_size));
        w_km1      = w_k - c_one;
        w_lim      = w_n + w_p - c_one;
        w_kend     = i_k - KW'(1);
        w_kx_end   = (r_kx == w_kend);
        w_ky_end   = (r_ky == w_kend);
        w_tap_last = w_kx_end && w_ky_end;
        w_ox_step  = r_ox0 + w_s;
        w_row_wrap = (w_ox_step + w_km1) > w_lim;

        w_kx_n = r_kx;
        w_ky_n = r_ky;
        w_ox_n = r_ox0;
        w_oy_n = r_oy0;
        if (i_load) begin
            w_kx_n = '0;
            w_ky_n = '0;
            w_ox_n = -w_p;
            w_oy_n = -w_p;
        end else if (i_adv) begin
            w_kx_n = w_kx_end ? '0 : r_kx + KW'(1);
            if (w_kx_end)
                w_ky_n = w_ky_end ? '0 : r_ky + KW'(1);
            if (w_tap_last) begin
                w_ox_n = w_row_wrap ? -w_p : w_ox_step;
                if (w_row_wrap)
                    w_oy_n = r_oy0 + w_s;
            end
        end

        // Flags describe the tap the counters are about to hold.
        o_y_nxt     = w_oy_n + signed'(CW'(w_ky_n));
        o_x_nxt     = w_ox_n + signed'(CW'(w_kx_n));
        o_pad_nxt   = (o_y_nxt < 0) || (o_x_nxt < 0) || (o_y_nxt >= w_n) || (o_x_nxt >= w_n);
        o_first_nxt = (w_kx_n == '0) && (w_ky_n == '0);
        o_last_nxt  = (w_kx_n == w_kend) && (w_ky_n == w_kend);
        o_wlast_nxt = o_last_nxt
                   && ((w_ox_n + w_s + w_km1) > w_lim)
                   && ((w_oy_n + w_s + w_km1) > w_lim);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_kx  <= '0;
            r_ky  <= '0;
            r_ox0 <= '0;
            r_oy0 <= '0;
        end else begin
            r_kx  <= w_kx_n;
            r_ky  <= w_ky_n;
            r_ox0 <= w_ox_n;
            r_oy0 <= w_oy_n;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifmap_window_addr_gen.sv
// ============================================================================
//  Module      : ifmap_window_addr_gen
//  Description : Emits one ifmap BRAM address per kernel tap for every output
//                window, with framing flags and a valid/ready handshake.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ifmap_window_addr_gen
    import bnn_pkg::*;
#(
    parameter int IMG_MAX = 32,
    parameter int K_MAX   = 7,
    parameter int CH_MAX  = 32,
    parameter int ADDR_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       clear,
    input  logic [$clog2(IMG_MAX):0]   image_size,
    input  logic [$clog2(CH_MAX):0]    number_channel,
    input  logic [$clog2(K_MAX):0]     kernel_size,
    input  logic                       padding,
    input  logic [1:0]                 stride,
    input  logic                       addr_ready,
    output logic                       addr_valid,
    output logic [ADDR_W-1:0]          address_ifmap,
    output logic                       pad_tap,
    output logic                       tap_first,
    output logic                       tap_last,
    output logic                       window_last,
    output logic [CH_MAX-1:0]          channel_en,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err
);

    localparam int IW = $clog2(IMG_MAX) + 1;
    localparam int KW = $clog2(K_MAX) + 1;
    localparam int NW = $clog2(CH_MAX) + 1;
    localparam int CW = $clog2(IMG_MAX) + 2;

    ifgen_state_t r_state, w_state_nxt;

    logic [IW-1:0]     r_size;
    logic [NW-1:0]     r_nch;
    logic [KW-1:0]     r_k;
    logic              r_pad;
    logic [1:0]        r_s;

    logic [ADDR_W-1:0] r_addr;
    logic              r_pad_tap, r_first, r_last, r_wlast, r_cfg_err;
    logic [CH_MAX-1:0] r_ch_en;

    logic [KW-1:0]        w_p;
    logic                 w_cfg_bad, w_accept, w_xfer, w_load, w_adv;
    logic signed [CW-1:0] w_y_nxt, w_x_nxt;
    logic                 w_pad_nxt, w_first_nxt, w_last_nxt, w_wlast_nxt;
    logic [ADDR_W-1:0]    w_y_u, w_x_u, w_addr;
    logic [CH_MAX-1:0]    w_ch_mask;

    always_comb begin
        w_p = '0;
        unique case (r_pad)
            PAD_NONE: w_p = '0;
            PAD_SAME: w_p = (r_k - KW'(1)) >> 1;
        endcase
    end

    assign w_cfg_bad = (r_k == '0) || (r_k > KW'(K_MAX)) || (r_s == '0)
                    || (r_size == '0) || (r_size > IW'(IMG_MAX)) || (r_nch == '0)
                    || (8'(r_k) > (8'(r_size) + 8'(w_p) + 8'(w_p)));

    assign w_accept = (r_state == IDLE) && start && !clear;
    assign w_xfer   = (r_state == RUN) && addr_ready;
    assign w_load   = (r_state == SETUP) && !w_cfg_bad && !clear;
    assign w_adv    = w_xfer && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = w_cfg_bad ? DONE : RUN;
            RUN:     if (w_xfer && r_wlast) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clear)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_size <= '0;
            r_nch  <= '0;
            r_k    <= '0;
            r_pad  <= 1'b0;
            r_s    <= '0;
        end else if (w_accept) begin
            r_size <= image_size;
            r_nch  <= number_channel;
            r_k    <= kernel_size;
            r_pad  <= padding;
            r_s    <= stride;
        end
    end

    ifmap_tap_counter #(
        .CW (CW),
        .KW (KW),
        .IW (IW)
    ) u_tap_counter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_adv       (w_adv),
        .i_k         (r_k),
        .i_p         (w_p),
        .i_s         (r_s),
        .i_size      (r_size),
        .o_y_nxt     (w_y_nxt),
        .o_x_nxt     (w_x_nxt),
        .o_pad_nxt   (w_pad_nxt),
        .o_first_nxt (w_first_nxt),
        .o_last_nxt  (w_last_nxt),
        .o_wlast_nxt (w_wlast_nxt)
    );

    // Coordinates are non-negative whenever the address is actually used.
    assign w_y_u  = {{(ADDR_W-CW){1'b0}}, w_y_nxt};
    assign w_x_u  = {{(ADDR_W-CW){1'b0}}, w_x_nxt};
    assign w_addr = w_y_u * ADDR_W'(r_size) + w_x_u;

    always_comb begin
        w_ch_mask = '0;
        for (int i = 0; i < CH_MAX; i++)
            w_ch_mask[i] = (i < int'(r_nch));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_pad_tap <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_wlast   <= 1'b0;
            r_ch_en   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_state_nxt != RUN) begin
                r_addr    <= '0;
                r_pad_tap <= 1'b0;
                r_first   <= 1'b0;
                r_last    <= 1'b0;
                r_wlast   <= 1'b0;
            end else if (w_load || w_adv) begin
                r_addr    <= w_pad_nxt ? '0 : w_addr;
                r_pad_tap <= w_pad_nxt;
                r_first   <= w_first_nxt;
                r_last    <= w_last_nxt;
                r_wlast   <= w_wlast_nxt;
            end

            if (w_state_nxt == IDLE)
                r_ch_en <= '0;
            else if (w_load)
                r_ch_en <= w_ch_mask;

            if (w_accept)
                r_cfg_err <= 1'b0;
            else if ((r_state == SETUP) && w_cfg_bad && !clear)
                r_cfg_err <= 1'b1;
        end
    end

    assign addr_valid    = (r_state == RUN);
    assign busy          = (r_state == SETUP) || (r_state == RUN);
    assign done          = (r_state == DONE);
    assign address_ifmap = r_addr;
    assign pad_tap       = r_pad_tap;
    assign tap_first     = r_first;
    assign tap_last      = r_last;
    assign window_last   = r_wlast;
    assign channel_en    = r_ch_en;
    assign cfg_err       = r_cfg_err;

endmodule

`default_nettype wire

// File: doc/ifmap_window_addr_gen.md
Name: ifmap_window_addr_gen

Overview:
- Parametrised successor to the fixed 3x3 ifmap controller in the BNN conv datapath.
- Walks an image_size x image_size input feature map in raster order of output windows. For each window it emits one ifmap BRAM address per kernel tap (ky-major, kx-minor).
- Supports run-time kernel size, stride, zero/"same" padding and channel count.
- Emits tap/window framing flags for the PE array, using a valid/ready handshake so the PE/weight side can stall it.

Parameters:
IMG_MAX, 32, largest supported image side (image_size <= IMG_MAX)
K_MAX, 7, largest supported kernel side
CH_MAX, 32, number of channel lanes per ifmap word (width of channel_en)
ADDR_W, 16, ifmap BRAM address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
clear  in  1  synchronous abort; returns to IDLE next cycle from any state
image_size  in  $clog2(IMG_MAX)+1  image side, legal 1..IMG_MAX
number_channel  in  $clog2(CH_MAX)+1  active channels, legal 1..CH_MAX
kernel_size  in  $clog2(K_MAX)+1  kernel side K, legal 1..K_MAX
padding  in  1  0 = none (P=0), 1 = same (P=(K-1)>>1)
stride  in  2  stride S, legal 1..3
addr_ready  in  1  consumer accepts current tap
addr_valid  out  1  current tap valid
address_ifmap  out  ADDR_W  y*image_size+x; 0 when pad_tap
pad_tap  out  1  tap lies outside image; consumer substitutes padding value
tap_first  out  1  first tap (ky=0,kx=0) of a window
tap_last  out  1  last tap of a window (PE_start equivalent)
window_last  out  1  tap_last of final window of the map
channel_en  out  CH_MAX  thermometer mask, lower number_channel bits set
busy  out  1  high in SETUP/RUN
done  out  1  one-cycle pulse on completion or config error
cfg_err  out  1  sticky until next accepted start; set on illegal config

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, including channel_en and cfg_err. Counters 0.
- Config latching: all config inputs are latched on the accepted start. Later input changes have no effect until the next start.
- FSM states: IDLE, SETUP, RUN, DONE.
  - IDLE: start=1 -> SETUP; cfg_err cleared. Start in any other state is ignored.
  - SETUP (1 cycle): checks config legality. Illegal if any of: K=0, K>K_MAX, S=0, image_size=0, number_channel=0, K>image_size+2P.
    - Illegal -> DONE with cfg_err=1; no taps are emitted.
    - Legal -> RUN with oy0=ox0=-P, ky=kx=0. channel_en is driven from number_channel, held through RUN and DONE, and cleared back in IDLE.
  - RUN: addr_valid=1.
    - Transfer occurs when addr_valid & addr_ready. Without a transfer, every output holds stable (no bubbles, no drops).
    - On each transfer:
      - kx++; at kx=K-1, kx=0 and ky++.
      - At ky=K-1 & kx=K-1 (tap_last): ky=0 and ox0+=S.
      - Row wrap: if ox0+S+K-1 > image_size-1+P, then ox0=-P and oy0+=S.
      - Final window: if oy0+S+K-1 > image_size-1+P as well, this tap is window_last -> DONE.
  - DONE (1 cycle): done=1, addr_valid=0 -> IDLE.
- Tap coordinates: y=oy0+ky, x=ox0+kx, held in signed registers $clog2(IMG_MAX)+2 bits wide.
  - pad_tap = (y<0)|(x<0)|(y>=image_size)|(x>=image_size).
  - P=0 never produces pad_tap.
- Address arithmetic: y*image_size+x, computed at ADDR_W, no truncation for IMG_MAX=32. Output is registered, so flags and address change together, one cycle after the transfer.
- Output window count: Wo=floor((image_size+2P-K)/S)+1 per side. Total taps = Wo*Wo*K*K. No divider is used; termination follows from the origin comparisons above.
- Degenerate K=1: tap_first and tap_last are both high on every tap.
- Single-window case (K=image_size+2P): exactly K*K taps; window_last is on the last one.
- clear: has priority over all transitions. Next cycle is IDLE with outputs at reset values except cfg_err, which holds. No done pulse is produced.
- clear and start in the same cycle: clear wins; start is ignored.
- Reset mid-RUN: immediate return to IDLE, no done.

Decomposition:
- Package bnn_pkg holds the state enum ifgen_state_t (IDLE, SETUP, RUN, DONE) and the pad-mode constants PAD_NONE and PAD_SAME.
- Sub-module ifmap_tap_counter holds the kx/ky/ox0/oy0 nested counters with advance/wrap/last outputs. The top module owns the FSM, config latch, address multiply and handshake.

Test Plan:
- image_size=5, K=3, S=1, pad=0, ready=1: 81 taps. First three addresses are 0,1,2, then 5,6,7. Window 2 starts at address 1. window_last on address 24. done follows 1 cycle later.
- image_size=4, K=3, S=1, pad=1: 144 taps. First tap has pad_tap=1 and address 0. Window 0 row 1 sequence is pad, 0, 1. Tap (y=1,x=1) has address 5.
- image_size=7, K=3, S=2, pad=0: Wo=3, 81 taps. Second window's first address is 2; fourth window's first address is 14.
- Random addr_ready (~50%): address/flag sequence identical to the ready=1 run, and outputs are stable while addr_valid & !addr_ready.
- K=5, image_size=3, pad=0 -> cfg_err=1, done pulse in the 2nd cycle after start, zero taps. Separately, number_channel=6 -> channel_en=0x0000003F during RUN.
- clear asserted mid-RUN (tap 10) -> next cycle IDLE, addr_valid=0, no done. A new start then restarts from address 0.
